// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: shifts one bit per clock until the leading one reaches the MSB.
// Optional two's-complement mode is enabled by defining SIGNED_NORM_EN (adds the sign port).
module seq_normalizer #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
`ifdef SIGNED_NORM_EN
    input  logic             sign,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             is_zero;
    logic             stop;

`ifdef SIGNED_NORM_EN
    logic sgn;

    // Signed mode halts once the top two bits differ, or at the last position for -1.
    always_comb begin
        if (sgn)
            stop = (work[WIDTH-1] != work[WIDTH-2]) || (cnt == CW'(WIDTH-1));
        else
            stop = work[WIDTH-1];
    end
`else
    always_comb stop = work[WIDTH-1];
`endif

    assign accept  = start && (state == IDLE || state == DONE);
    assign is_zero = (work == '0);
    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SHIFT;
            SHIFT:   if (is_zero || stop) state_n = DONE;
            DONE:    state_n = accept ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // The working register and counter are internal; the visible results only move on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            cnt   <= '0;
            out   <= '0;
            count <= '0;
            zero  <= 1'b0;
`ifdef SIGNED_NORM_EN
            sgn   <= 1'b0;
`endif
        end else if (accept) begin
            work <= a;
            cnt  <= '0;
`ifdef SIGNED_NORM_EN
            sgn  <= sign;
`endif
        end else if (state == SHIFT) begin
            if (is_zero) begin
                out   <= '0;
                count <= '0;
                zero  <= 1'b1;
            end else if (stop) begin
                out   <= work;
                count <= cnt;
                zero  <= 1'b0;
            end else begin
                work <= work << 1;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: directed cases, mid-operation reset, then random traffic.
module tb_seq_normalizer;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
`ifdef SIGNED_NORM_EN
    logic          sign;
`endif
    logic          busy, done, zero;
    logic [W-1:0]  out;
    logic [CW-1:0] count;

    seq_normalizer #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a),
`ifdef SIGNED_NORM_EN
        .sign(sign),
`endif
        .busy(busy), .done(done), .out(out), .count(count), .zero(zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] out;
        int           count;
        logic         zero;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];

    // Reference: count redundant leading bits directly from the operand.
    function automatic exp_t model(logic [W-1:0] v, logic s, int acc);
        exp_t e;
        int   k = 0;
        if (v == '0) begin
            e.out = '0; e.count = 0; e.zero = 1'b1; e.lat = 1;
        end else begin
            if (!s) while (!v[W-1-k]) k++;
            else    while (k < W-1 && v[W-2-k] == v[W-1]) k++;
            e.out = v << k; e.count = k; e.zero = 1'b0; e.lat = k + 1;
        end
        e.acc = acc;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; checks holds and exclusivity each cycle.
    logic [W-1:0]  p_out;
    logic [CW-1:0] p_count;
    logic          p_zero;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                p_out = out; p_count = count; p_zero = zero;
                continue;
            end
            check("busy_done_excl", 32'(busy && done), 0);
            if (done) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("out",     32'(out),   32'(e.out));
                    check("count",   32'(count), 32'(e.count));
                    check("zero",    32'(zero),  32'(e.zero));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end else begin
                check("hold_results", {out, count, zero}, {p_out, p_count, p_zero});
            end
            p_out = out; p_count = count; p_zero = zero;
        end
    end

    task automatic set_sign(logic s);
`ifdef SIGNED_NORM_EN
        sign = s;
`endif
    endtask

    task automatic issue(logic [W-1:0] v, logic s);
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 50 cycles");
        end
        start = 1'b1; a = v; set_sign(s);
        @(posedge clk); #1;
        q.push_back(model(v, s, cyc));
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic         s;
        int           n;
        reset = 1'b1; start = 1'b0; a = '0; set_sign(1'b0);
        @(negedge clk); @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out", {out, count, zero}, 0);
        reset = 1'b0;

        issue(8'b10000111, 1'b0);
        issue(8'b00000111, 1'b0);
        issue(8'b00000001, 1'b0);
        issue(8'h00, 1'b0);
        issue(8'b01000000, 1'b0);
`ifdef SIGNED_NORM_EN
        issue(8'b11110000, 1'b1);
        issue(8'hFF, 1'b1);
        issue(8'h00, 1'b1);
        issue(8'b00000111, 1'b1);
`endif

        // Operation disturbed by a second start, then killed by reset.
        issue(8'b00010000, 1'b0);
        @(negedge clk); start = 1'b1; a = 8'hFF;
        @(negedge clk); start = 1'b0; reset = 1'b1;
        q.delete();
        @(negedge clk); @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_out", {out, count, zero}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(8'b00100000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && $urandom_range(0, 3) != 0) begin
                v = W'($urandom) >> $urandom_range(0, W);
`ifdef SIGNED_NORM_EN
                s = 1'($urandom);
                if ($urandom_range(0, 3) == 0) v = ~v;
`else
                s = 1'b0;
`endif
                start = 1'b1; a = v; set_sign(s);
                @(posedge clk); #1;
                q.push_back(model(v, s, cyc));
                start = 1'b0;
            end else if (busy) begin
                start = 1'($urandom); a = W'($urandom); set_sign(1'($urandom));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("drain", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
